// File: rtl/mem_if_pkg.sv
// Shared widths, FSM states and operation codes
// for the cache line-refill / write-back path.
package mem_if_pkg;

  localparam int LINE_W  = 128;
  localparam int LADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/line_ram.sv
// Line storage: 2^IDX_W x 128, synchronous write,
// registered read port that only updates on re.
module line_ram
  import mem_if_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory answering one 128-bit
// read or write at a time with a mem_ready pulse.
module line_mem_responder
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int IDX_W   = 8
) (
  input  logic               clk,
  input  logic               proc_reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [LADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]  mem_wdata,
  output logic [LINE_W-1:0]  mem_rdata,
  output logic               mem_ready,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count
);

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t            state_q, state_n;
  logic [7:0]        cnt_q, cnt_n;
  op_t               op_q, op_sel;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic              ready_q;
  logic [31:0]       rd_cnt_q;
  logic [31:0]       wr_cnt_q;
  logic              req;
  logic              ram_we;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_addr;
  logic              unused_addr;

  assign unused_addr = ^mem_addr[LADDR_W-1:IDX_W];

  assign req    = mem_read | mem_write;
  assign op_sel = mem_write ? OP_WR : OP_RD;

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = idx_q;
    unique case (state_q)
      IDLE: begin
        ram_addr = mem_addr[IDX_W-1:0];
        if (req) begin
          cnt_n = LAT_M1;
          // No BUSY phase at LATENCY=1: read the RAM now
          if (LATENCY == 1) begin
            state_n = RESP;
            ram_re  = (op_sel == OP_RD);
          end else begin
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_n = cnt_q - 8'd1;
        if (cnt_n == 8'd0) begin
          state_n = RESP;
          ram_re  = (op_q == OP_RD);
        end
      end
      RESP: begin
        ram_we  = (op_q == OP_WR);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (proc_reset) begin
      state_n = IDLE;
      cnt_n   = 8'd0;
      ram_we  = 1'b0;
      ram_re  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      op_q     <= OP_RD;
      idx_q    <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ready_q <= (state_n == RESP);
      if (state_q == IDLE && req) begin
        op_q    <= op_sel;
        idx_q   <= mem_addr[IDX_W-1:0];
        wdata_q <= mem_wdata;
      end
      if (state_q == RESP) begin
        if (op_q == OP_RD) begin
          rd_cnt_q <= rd_cnt_q + 32'd1;
        end else begin
          wr_cnt_q <= wr_cnt_q + 32'd1;
        end
      end
    end
  end

  line_ram #(
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (proc_reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign mem_ready = ready_q;
  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;

endmodule
